// File: rtl/fifo_rd_skid_if.sv
// rtl/fifo_rd_skid_if.sv - FIFO read port and output stream bundle for fifo_rd_skid
interface fifo_rd_skid_if #(
    parameter int DSIZE = 8
);
    logic [DSIZE-1:0] fifo_rdata;
    logic             fifo_rempty;
    logic             fifo_rinc;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    // master: the skid adapter (pops the FIFO, drives the stream)
    modport master (
        input  fifo_rdata,
        input  fifo_rempty,
        input  m_ready,
        output fifo_rinc,
        output m_data,
        output m_valid
    );

    // slave: the FIFO read side plus the stream consumer
    modport slave (
        output fifo_rdata,
        output fifo_rempty,
        output m_ready,
        input  fifo_rinc,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry skid adapter from FIFO read port to valid/ready stream; FIFO_RD_CNT_EN adds xfer_cnt
module fifo_rd_skid #(
    parameter int DSIZE = 8
) (
    input  logic           rclk,
    input  logic           rrst_n,
    fifo_rd_skid_if.master bus
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]    xfer_cnt
`endif
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DSIZE-1:0] out_q, out_d;
    logic [DSIZE-1:0] skid_q, skid_d;
    logic             pop;
    logic             take;

    // Pop and valid decode only registered state, so m_ready never reaches fifo_rinc.
    assign pop         = !bus.fifo_rempty && ((state_q == S_EMPTY) || (state_q == S_ONE));
    assign bus.m_valid = (state_q == S_ONE) || (state_q == S_TWO);
    assign take        = bus.m_valid && bus.m_ready;

    assign bus.fifo_rinc = pop;
    assign bus.m_data    = out_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (pop) begin
                    out_d   = bus.fifo_rdata;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (pop && take) begin
                    out_d = bus.fifo_rdata;
                end else if (pop) begin
                    skid_d  = bus.fifo_rdata;
                    state_d = S_TWO;
                end else if (take) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (take) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_RD_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = take ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule
